// File: rtl/mor1kx_spr_access_ctrl.sv
// mor1kx_spr_access_ctrl: arbitrates CPU/debug SPR accesses, serving group-0 config reads locally and the rest over the SPR bus.
module mor1kx_spr_access_ctrl #(
  parameter string FEATURE_DEBUGUNIT = "NONE",
  parameter string OPTION_ARB_MODE = "ROUNDROBIN",
  parameter int OPTION_SPR_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [15:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_ack_o,
  output logic        cpu_err_o,
  input  logic        du_req_i,
  input  logic        du_we_i,
  input  logic [15:0] du_addr_i,
  input  logic [31:0] du_wdata_i,
  output logic        du_ack_o,
  output logic        du_err_o,
  output logic [31:0] rdata_o,
  output logic [3:0]  cfg_idx_o,
  input  logic [31:0] cfg_data_i,
  output logic        spr_bus_stb_o,
  output logic        spr_bus_we_o,
  output logic [15:0] spr_bus_addr_o,
  output logic [31:0] spr_bus_dat_o,
  input  logic        spr_bus_ack_i,
  input  logic [31:0] spr_bus_dat_i,
  output logic        busy_o
);
  localparam bit DU_EN = FEATURE_DEBUGUNIT != "NONE";
  localparam bit RR = OPTION_ARB_MODE == "ROUNDROBIN";
  localparam logic [7:0] TO_LAST = 8'(OPTION_SPR_TIMEOUT - 1);
  typedef enum logic [1:0] {IDLE, CFG, BUS, RESP} state_t;
  state_t state, state_nxt;
  logic du_req, req_any, pick_du, sel_we, sel_cfg, timeout;
  logic gnt_du, last_du, we_q, err_q;
  logic [15:0] sel_addr, addr_q;
  logic [31:0] wdata_q, rdata_q;
  logic [7:0] cnt;
  assign du_req = DU_EN && du_req_i;
  assign req_any = cpu_req_i | du_req;
  // last_du resets high so the CPU wins the first contention
  assign pick_du = du_req & (!cpu_req_i | (RR & !last_du));
  assign sel_we = pick_du ? du_we_i : cpu_we_i;
  assign sel_addr = pick_du ? du_addr_i : cpu_addr_i;
  assign sel_cfg = sel_addr[15:11] == 5'd0 && sel_addr[10:0] <= 11'd10;
  assign timeout = cnt == TO_LAST;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: state_nxt = req_any ? (sel_cfg ? CFG : BUS) : IDLE;
      CFG:  state_nxt = RESP;
      BUS:  state_nxt = (spr_bus_ack_i | timeout) ? RESP : BUS;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt_du <= 1'b0;
      last_du <= 1'b1;
      we_q <= 1'b0;
      err_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_any) begin
        gnt_du <= pick_du;
        last_du <= pick_du;
        we_q <= sel_we;
        addr_q <= sel_addr;
        wdata_q <= pick_du ? du_wdata_i : cpu_wdata_i;
        cnt <= '0;
      end
      if (state == CFG) begin
        rdata_q <= we_q ? '0 : cfg_data_i;
        err_q <= we_q;
      end
      if (state == BUS) begin
        cnt <= cnt + 8'd1;
        if (spr_bus_ack_i) begin
          rdata_q <= we_q ? '0 : spr_bus_dat_i;
          err_q <= 1'b0;
        end else if (timeout) begin
          rdata_q <= '0;
          err_q <= 1'b1;
        end
      end
    end
  end
  assign cpu_ack_o = state == RESP && !gnt_du;
  assign du_ack_o = DU_EN && state == RESP && gnt_du;
  assign cpu_err_o = cpu_ack_o & err_q;
  assign du_err_o = du_ack_o & err_q;
  assign rdata_o = state == RESP ? rdata_q : '0;
  assign cfg_idx_o = state == CFG ? addr_q[3:0] : '0;
  assign spr_bus_stb_o = state == BUS;
  assign spr_bus_we_o = state == BUS && we_q;
  assign spr_bus_addr_o = state == BUS ? addr_q : '0;
  assign spr_bus_dat_o = state == BUS ? wdata_q : '0;
  assign busy_o = state != IDLE;
endmodule

// File: tb/tb_mor1kx_spr_access_ctrl.sv
// tb_mor1kx_spr_access_ctrl: directed checks on round-robin (u_a), cpu-first (u_b) and no-debug-unit (u_c) instances.
module tb_mor1kx_spr_access_ctrl;
  logic clk = 0, rst = 1;
  logic cpu_req = 0, cpu_we = 0, du_req = 0, du_we = 0, bus_ack = 0;
  logic [15:0] cpu_addr = 0, du_addr = 0;
  logic [31:0] cpu_wdata = 0, du_wdata = 0, bus_dat = 0;
  logic cpu_ack[3], cpu_err[3], du_ack[3], du_err[3], stb[3], bwe[3], busy[3];
  logic [31:0] rdata[3], bdat[3], cfg_data[3];
  logic [15:0] baddr[3];
  logic [3:0] cfg_idx[3];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  assign cfg_data[0] = 32'h700 | 32'(cfg_idx[0]);
  assign cfg_data[1] = 32'h700 | 32'(cfg_idx[1]);
  assign cfg_data[2] = 32'h700 | 32'(cfg_idx[2]);
  mor1kx_spr_access_ctrl #(.FEATURE_DEBUGUNIT("ENABLED"), .OPTION_ARB_MODE("ROUNDROBIN"), .OPTION_SPR_TIMEOUT(4)) u_a (
    .clk(clk), .rst(rst), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack[0]), .cpu_err_o(cpu_err[0]), .du_req_i(du_req), .du_we_i(du_we), .du_addr_i(du_addr),
    .du_wdata_i(du_wdata), .du_ack_o(du_ack[0]), .du_err_o(du_err[0]), .rdata_o(rdata[0]), .cfg_idx_o(cfg_idx[0]),
    .cfg_data_i(cfg_data[0]), .spr_bus_stb_o(stb[0]), .spr_bus_we_o(bwe[0]), .spr_bus_addr_o(baddr[0]),
    .spr_bus_dat_o(bdat[0]), .spr_bus_ack_i(bus_ack), .spr_bus_dat_i(bus_dat), .busy_o(busy[0]));
  mor1kx_spr_access_ctrl #(.FEATURE_DEBUGUNIT("ENABLED"), .OPTION_ARB_MODE("CPU_FIRST"), .OPTION_SPR_TIMEOUT(16)) u_b (
    .clk(clk), .rst(rst), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack[1]), .cpu_err_o(cpu_err[1]), .du_req_i(du_req), .du_we_i(du_we), .du_addr_i(du_addr),
    .du_wdata_i(du_wdata), .du_ack_o(du_ack[1]), .du_err_o(du_err[1]), .rdata_o(rdata[1]), .cfg_idx_o(cfg_idx[1]),
    .cfg_data_i(cfg_data[1]), .spr_bus_stb_o(stb[1]), .spr_bus_we_o(bwe[1]), .spr_bus_addr_o(baddr[1]),
    .spr_bus_dat_o(bdat[1]), .spr_bus_ack_i(bus_ack), .spr_bus_dat_i(bus_dat), .busy_o(busy[1]));
  mor1kx_spr_access_ctrl u_c (
    .clk(clk), .rst(rst), .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_ack_o(cpu_ack[2]), .cpu_err_o(cpu_err[2]), .du_req_i(du_req), .du_we_i(du_we), .du_addr_i(du_addr),
    .du_wdata_i(du_wdata), .du_ack_o(du_ack[2]), .du_err_o(du_err[2]), .rdata_o(rdata[2]), .cfg_idx_o(cfg_idx[2]),
    .cfg_data_i(cfg_data[2]), .spr_bus_stb_o(stb[2]), .spr_bus_we_o(bwe[2]), .spr_bus_addr_o(baddr[2]),
    .spr_bus_dat_o(bdat[2]), .spr_bus_ack_i(bus_ack), .spr_bus_dat_i(bus_dat), .busy_o(busy[2]));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1; cpu_req = 0; du_req = 0; bus_ack = 0;
    tick; tick;
    rst = 0;
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({busy[0], cpu_ack[0], du_ack[0], stb[0], bwe[0]} !== 5'b0 || rdata[0] !== 0 || cfg_idx[0] !== 0 || baddr[0] !== 0 || bdat[0] !== 0) begin
      errors++; $display("FAIL reset_outputs: busy=%b ack=%b stb=%b rdata=%h idx=%h want all 0", busy[0], cpu_ack[0], stb[0], rdata[0], cfg_idx[0]);
    end
  endtask

  task automatic test_cfg_read;
    do_reset;
    cpu_we = 0; cpu_addr = 16'h0001; cpu_req = 1;
    tick;
    checks++;
    if (cfg_idx[0] !== 4'd1 || cpu_ack[0] !== 0 || busy[0] !== 1) begin
      errors++; $display("FAIL cfg_read_n1: idx=%0d ack=%b busy=%b want 1 0 1", cfg_idx[0], cpu_ack[0], busy[0]);
    end
    tick;
    checks++;
    if (cpu_ack[0] !== 1 || cpu_err[0] !== 0 || rdata[0] !== 32'h0000_0701 || du_ack[0] !== 0) begin
      errors++; $display("FAIL cfg_read_n2: ack=%b err=%b rdata=%h du_ack=%b want 1 0 00000701 0", cpu_ack[0], cpu_err[0], rdata[0], du_ack[0]);
    end
    cpu_req = 0;
    tick;
    checks++;
    if (cpu_ack[0] !== 0 || rdata[0] !== 0 || busy[0] !== 0) begin
      errors++; $display("FAIL cfg_read_after: ack=%b rdata=%h busy=%b want 0 0 0", cpu_ack[0], rdata[0], busy[0]);
    end
  endtask

  task automatic test_cfg_write;
    do_reset;
    cpu_we = 1; cpu_addr = 16'h0002; cpu_wdata = 32'hCAFE_0001; cpu_req = 1;
    tick;
    checks++;
    if (stb[0] !== 0 || cpu_ack[0] !== 0) begin
      errors++; $display("FAIL cfg_write_n1: stb=%b ack=%b want 0 0", stb[0], cpu_ack[0]);
    end
    tick;
    checks++;
    if (cpu_ack[0] !== 1 || cpu_err[0] !== 1 || rdata[0] !== 0 || stb[0] !== 0) begin
      errors++; $display("FAIL cfg_write_n2: ack=%b err=%b rdata=%h stb=%b want 1 1 0 0", cpu_ack[0], cpu_err[0], rdata[0], stb[0]);
    end
    cpu_req = 0; cpu_we = 0;
    tick;
  endtask

  task automatic test_cfg_boundary;
    do_reset;
    cpu_we = 0; cpu_addr = 16'h000A; cpu_req = 1;
    tick;
    checks++;
    if (cfg_idx[0] !== 4'd10 || stb[0] !== 0) begin
      errors++; $display("FAIL cfg_idx10: idx=%0d stb=%b want 10 0", cfg_idx[0], stb[0]);
    end
    tick;
    checks++;
    if (cpu_ack[0] !== 1 || rdata[0] !== 32'h70A) begin
      errors++; $display("FAIL cfg_idx10_resp: ack=%b rdata=%h want 1 0000070a", cpu_ack[0], rdata[0]);
    end
    cpu_req = 0;
    tick;
    cpu_addr = 16'h000B; cpu_req = 1;
    tick;
    checks++;
    if (stb[0] !== 1 || baddr[0] !== 16'h000B || cfg_idx[0] !== 0) begin
      errors++; $display("FAIL idx11_bus: stb=%b addr=%h idx=%0d want 1 000b 0", stb[0], baddr[0], cfg_idx[0]);
    end
    bus_ack = 1; bus_dat = 32'h1111_2222;
    tick;
    bus_ack = 0; cpu_req = 0;
    checks++;
    if (cpu_ack[0] !== 1 || rdata[0] !== 32'h1111_2222) begin
      errors++; $display("FAIL idx11_resp: ack=%b rdata=%h want 1 11112222", cpu_ack[0], rdata[0]);
    end
    tick;
  endtask

  task automatic test_bus_read;
    do_reset;
    bus_ack = 1; bus_dat = 32'h5555_5555;
    tick;
    checks++;
    if (busy[0] !== 0 || cpu_ack[0] !== 0) begin
      errors++; $display("FAIL idle_bus_ack: busy=%b ack=%b want 0 0", busy[0], cpu_ack[0]);
    end
    bus_ack = 0;
    cpu_we = 0; cpu_addr = 16'h2800; cpu_req = 1;
    tick;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (stb[0] !== 1 || baddr[0] !== 16'h2800 || bwe[0] !== 0 || cpu_ack[0] !== 0) begin
        errors++; $display("FAIL bus_read_strobe%0d: stb=%b addr=%h we=%b ack=%b want 1 2800 0 0", i, stb[0], baddr[0], bwe[0], cpu_ack[0]);
      end
      tick;
    end
    bus_ack = 1; bus_dat = 32'hDEAD_BEEF;
    tick;
    bus_ack = 0; bus_dat = 0; cpu_req = 0;
    checks++;
    if (cpu_ack[0] !== 1 || cpu_err[0] !== 0 || rdata[0] !== 32'hDEAD_BEEF || stb[0] !== 0) begin
      errors++; $display("FAIL bus_read_resp: ack=%b err=%b rdata=%h stb=%b want 1 0 deadbeef 0", cpu_ack[0], cpu_err[0], rdata[0], stb[0]);
    end
    tick;
  endtask

  task automatic test_bus_write;
    do_reset;
    cpu_we = 1; cpu_addr = 16'h2801; cpu_wdata = 32'h1234_5678; cpu_req = 1;
    tick;
    checks++;
    if (stb[0] !== 1 || bwe[0] !== 1 || baddr[0] !== 16'h2801 || bdat[0] !== 32'h1234_5678) begin
      errors++; $display("FAIL bus_write_strobe: stb=%b we=%b addr=%h dat=%h want 1 1 2801 12345678", stb[0], bwe[0], baddr[0], bdat[0]);
    end
    bus_ack = 1; bus_dat = 32'hFFFF_FFFF;
    tick;
    bus_ack = 0; cpu_req = 0; cpu_we = 0;
    checks++;
    if (cpu_ack[0] !== 1 || cpu_err[0] !== 0 || rdata[0] !== 0) begin
      errors++; $display("FAIL bus_write_resp: ack=%b err=%b rdata=%h want 1 0 0", cpu_ack[0], cpu_err[0], rdata[0]);
    end
    tick;
  endtask

  task automatic test_timeout;
    do_reset;
    du_we = 1; du_addr = 16'h4800; du_wdata = 32'hABCD_0000; du_req = 1;
    tick;
    checks++;
    if (busy[2] !== 0 || stb[2] !== 0) begin
      errors++; $display("FAIL no_du_ignored: busy=%b stb=%b want 0 0", busy[2], stb[2]);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (stb[0] !== 1 || du_ack[0] !== 0) begin
        errors++; $display("FAIL timeout_strobe%0d: stb=%b du_ack=%b want 1 0", i, stb[0], du_ack[0]);
      end
      tick;
    end
    checks++;
    if (du_ack[0] !== 1 || du_err[0] !== 1 || stb[0] !== 0 || rdata[0] !== 0 || cpu_ack[0] !== 0) begin
      errors++; $display("FAIL timeout_resp: du_ack=%b du_err=%b stb=%b rdata=%h cpu_ack=%b want 1 1 0 0 0", du_ack[0], du_err[0], stb[0], rdata[0], cpu_ack[0]);
    end
    checks++;
    if (stb[1] !== 1 || du_ack[2] !== 0) begin
      errors++; $display("FAIL timeout16_pending: stb_b=%b du_ack_c=%b want 1 0", stb[1], du_ack[2]);
    end
    du_req = 0; du_we = 0;
    tick;
  endtask

  task automatic test_arb(input int s, input logic [3:0] exp_du, input string nm);
    logic seen;
    do_reset;
    cpu_we = 0; du_we = 0; cpu_addr = 16'h0001; du_addr = 16'h0002; cpu_req = 1; du_req = 1;
    for (int g = 0; g < 4; g++) begin
      seen = 0;
      for (int t = 0; t < 10 && !seen; t++) begin
        tick;
        seen = cpu_ack[s] | du_ack[s];
      end
      checks++;
      if (!seen) begin
        errors++; $display("FAIL %s_grant%0d: no ack within 10 cycles", nm, g);
      end else if (du_ack[s] !== exp_du[g]) begin
        errors++; $display("FAIL %s_grant%0d: du_granted=%b want %b", nm, g, du_ack[s], exp_du[g]);
      end
      if (du_ack[s]) du_req = 0;
      else cpu_req = 0;
      tick;
      cpu_req = 1; du_req = 1;
    end
    cpu_req = 0; du_req = 0;
    tick; tick; tick;
  endtask

  task automatic test_reset_mid;
    logic any_ack;
    do_reset;
    cpu_we = 0; cpu_addr = 16'h2800; cpu_req = 1;
    tick;
    tick;
    checks++;
    if (stb[0] !== 1) begin
      errors++; $display("FAIL mid_strobe2: stb=%b want 1", stb[0]);
    end
    rst = 1;
    tick;
    checks++;
    if (stb[0] !== 0 || busy[0] !== 0 || cpu_ack[0] !== 0) begin
      errors++; $display("FAIL mid_reset: stb=%b busy=%b ack=%b want 0 0 0", stb[0], busy[0], cpu_ack[0]);
    end
    rst = 0; cpu_req = 0;
    any_ack = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      any_ack |= cpu_ack[0] | du_ack[0];
    end
    checks++;
    if (any_ack !== 0) begin
      errors++; $display("FAIL mid_reset_noack: ack seen=%b want 0", any_ack);
    end
    cpu_addr = 16'h0003; cpu_req = 1;
    tick; tick;
    checks++;
    if (cpu_ack[0] !== 1 || cpu_err[0] !== 0 || rdata[0] !== 32'h703) begin
      errors++; $display("FAIL mid_reset_cfg: ack=%b err=%b rdata=%h want 1 0 00000703", cpu_ack[0], cpu_err[0], rdata[0]);
    end
    cpu_req = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_cfg_read;
    test_cfg_write;
    test_cfg_boundary;
    test_bus_read;
    test_bus_write;
    test_timeout;
    test_arb(0, 4'b1010, "rr");
    test_arb(1, 4'b0000, "cpu_first");
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule

// File: doc/mor1kx_spr_access_ctrl.md
Name: mor1kx_spr_access_ctrl

Overview:
- Sequences special-purpose-register (SPR) accesses from two requesters: the CPU pipeline and the debug unit.
- Arbitrates between the two requesters.
- Serves reads of the read-only group-0 configuration registers (VR..AVR) through an external combinational lookup.
- Forwards every other access to the shared SPR bus, with a bounded acknowledge timeout.
- Sits between the control stage and the SPR-bearing units (caches, MMUs, PIC, tick timer).

Parameters:
- FEATURE_DEBUGUNIT, "NONE": when "NONE", du_req_i is ignored and du_ack_o/du_err_o are tied 0.
- OPTION_ARB_MODE, "ROUNDROBIN": "ROUNDROBIN" alternates grants on contention; "CPU_FIRST" always grants the CPU on contention.
- OPTION_SPR_TIMEOUT, 16: bus cycles to wait for spr_bus_ack_i before erroring. Legal range 2..255.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cpu_req_i  in  1  CPU access request (level)
- cpu_we_i  in  1  CPU write(1)/read(0)
- cpu_addr_i  in  16  CPU SPR address; group = [15:11], index = [10:0]
- cpu_wdata_i  in  32  CPU write data
- cpu_ack_o  out  1  CPU completion pulse
- cpu_err_o  out  1  CPU error, valid with cpu_ack_o
- du_req_i, du_we_i, du_addr_i(16), du_wdata_i(32)  in  debug-unit equivalents of the CPU inputs
- du_ack_o, du_err_o  out  1  debug-unit equivalents of the CPU outputs
- rdata_o  out  32  read data, valid only with an ack
- cfg_idx_o  out  4  config register select: 0=VR 1=UPR 2=CPUCFGR 3=DMMUCFGR 4=IMMUCFGR 5=DCCFGR 6=ICCFGR 7=DCFGR 8=PCCFGR 9=VR2 10=AVR
- cfg_data_i  in  32  selected config register value (combinational from cfg_idx_o)
- spr_bus_stb_o  out  1  bus strobe
- spr_bus_we_o  out  1  bus write
- spr_bus_addr_o  out  16  bus address
- spr_bus_dat_o  out  32  bus write data
- spr_bus_ack_i  in  1  bus acknowledge
- spr_bus_dat_i  in  32  bus read data
- busy_o  out  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE; all outputs 0; timeout counter 0; last_grant=DU, so the CPU wins first contention.
- Reset mid-transaction: the access is aborted, spr_bus_stb_o is 0 the cycle after reset is sampled, and no ack is issued.
- Handshake:
  - A requester holds req, we, addr and wdata stable until its ack.
  - Each ack is a single-cycle pulse.
  - The requester must drop req in the cycle after ack; req still high in IDLE is a new access.
- States:
  - IDLE: sample the requests and grant one. Latch the granted we/addr/wdata and requester id.
    - Target is CFG if group==0 and index<=10; otherwise BUS.
  - CFG: cfg_idx_o=latched index[3:0]; cfg_idx_o is 0 in all other states. Latch cfg_data_i, go to RESP.
    - A write to CFG space has no effect; RESP carries err=1 and rdata_o=0.
  - BUS:
    - spr_bus_stb_o=1, and spr_bus_we/addr/dat_o = latched fields. All bus outputs are 0 outside BUS.
    - The counter clears on entry and increments each BUS cycle.
    - spr_bus_ack_i=1: latch spr_bus_dat_i (reads only; writes return 0), err=0, go to RESP.
    - Otherwise, when counter==OPTION_SPR_TIMEOUT-1: err=1, rdata=0, go to RESP.
    - Ack and timeout in the same cycle: ack wins.
  - RESP: pulse ack_o (and err_o if set) to the granted requester only; drive rdata_o; return to IDLE.
- Latency:
  - CFG read: req sampled in IDLE at cycle N, ack at N+2.
  - BUS access: spr_bus_stb_o high from N+1; ack_i at cycle M gives ack_o at M+1.
  - Timeout: ack_o at N+1+OPTION_SPR_TIMEOUT.
- rdata_o is 0 whenever no ack is asserted.
- spr_bus_ack_i outside BUS is ignored.
- Arbitration (IDLE only; no preemption):
  - ROUNDROBIN: on contention, grant the requester not in last_grant.
  - CPU_FIRST: on contention, grant the CPU.
  - last_grant updates on every grant.
- Single request: granted immediately regardless of mode.

Test Plan:
- Reset, then CPU read addr 0x0001 with cfg_data_i=0x0000_0701 for idx 1 -> cfg_idx_o=1 at N+1; cpu_ack_o=1, rdata_o=0x0000_0701, cpu_err_o=0 at N+2; du_ack_o stays 0.
- CPU write addr 0x0002 -> no bus strobe; cpu_ack_o=1 with cpu_err_o=1 and rdata_o=0 at N+2.
- CPU read addr 0x2800 (group 5), bus acks 3 cycles after strobe with 0xDEAD_BEEF -> spr_bus_addr_o=0x2800 and spr_bus_we_o=0 while strobed; cpu_ack_o=1 with rdata_o=0xDEAD_BEEF one cycle after ack.
- OPTION_SPR_TIMEOUT=4, DU write addr 0x4800, bus never acks (FEATURE_DEBUGUNIT="ENABLED") -> strobe high exactly 4 cycles; du_ack_o=1 and du_err_o=1 the next cycle.
- ROUNDROBIN, CPU and DU both request continuously from reset (each re-requesting after its gap) -> grant order CPU, DU, CPU, DU.
- CPU_FIRST -> CPU granted every contention.
- Assert rst during a BUS access at cycle 2 of the strobe -> spr_bus_stb_o=0 next cycle; no ack pulse; busy_o=0; a following CFG read completes normally.
